if_id_queue: RTL and testbench
==============================

# if_id_queue

Parametrised IF/ID pipeline boundary: a small FIFO that decouples instruction fetch from decode. It sits between the fetch unit and the decode stage. Fetched instructions are buffered so that RAM-conflict bubbles and load-use stalls do not have to stall fetch immediately. The output register drives decode with the same hold, flush and NOP-insert semantics as a plain IF/ID register.

## Interface
Parameters:
- IW, 16: instruction width.
- AW, 16: PC width.
- DEPTH, 4: queue entries; power of two, ≥2.
- NOP, 16'h0800: instruction inserted on bubble, flush or empty.
- PC_START, 16'h0000: pc_out reset value.

Ports:
- CLK  in  1  clock, rising edge.
- RSTboot  in  1  reset, asynchronous, active-low.
- fetch_valid  in  1  fetch presents an instruction this cycle.
- fetch_ready  out  1  queue can accept an instruction.
- instruction_in  in  IW  fetched instruction.
- pc_in  in  AW  PC of instruction_in.
- flush  in  1  redirect (branch or jump); discards all buffered instructions.
- ramSlot  in  1  structural bubble; decode receives NOP this cycle.
- loadSlot  in  1  load-use stall; decode output held.
- instruction_out  out  IW  instruction to decode.
- pc_out  out  AW  PC to decode.
- valid_out  out  1  instruction_out is a real fetched instruction.
- count  out  $clog2(DEPTH+1)  current queue occupancy.

## Operation
- Storage: DEPTH-entry circular buffer of {instruction, pc}.
  - Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - count tracks occupancy from 0 to DEPTH.
- Push: occurs when fetch_valid && fetch_ready && !flush.
- fetch_ready = (count != DEPTH). It depends only on registered state. A pop in the same cycle does not raise it.
- Output update at each rising edge, highest priority first:
  1. flush:
     - instruction_out←NOP, valid_out←0, pc_out holds.
     - Queue emptied (pointers and count zeroed).
     - The same-cycle fetch_valid instruction is dropped.
  2. ramSlot:
     - instruction_out←NOP, valid_out←0, pc_out holds.
     - No pop. Push still allowed.
  3. loadSlot:
     - All outputs hold. No pop. Push still allowed.
  4. Advance, queue non-empty:
     - Pop the head into {instruction_out, pc_out}, valid_out←1.
  5. Advance, queue empty:
     - instruction_out←NOP, valid_out←0, pc_out holds.
     - Behaviour with fetch_valid in this case depends on IFQ_BYPASS_EN (see Configuration).
- A simultaneous push and pop leaves count unchanged, including when count==DEPTH−1 or count==1.
- Order is strictly FIFO. No instruction is duplicated or lost except on flush.

## Timing
- Reset (RSTboot low, asynchronous):
  - instruction_out=NOP, pc_out=PC_START, valid_out=0.
  - count=0, pointers=0, fetch_ready=1.
  - Release is synchronous to the next CLK edge, with no output glitch.
- Reset asserted mid-operation discards the queue contents immediately.
- Latency without bypass:
  - An instruction pushed at edge N appears on instruction_out at edge N+1 at the earliest.
- Stall and bubble release:
  - The first advancing edge after loadSlot or ramSlot drops pops the oldest pending entry.
- Throughput: one instruction per cycle sustained while advancing and fetch_valid is held.
- Full queue with decode stalled: fetch_ready=0. The fetch unit must hold instruction_in and pc_in until it sees fetch_ready=1.
- flush takes effect at a single edge. At edge F+1, with fetch_valid, the new target instruction is pushed normally.

## Configuration
- IFQ_BYPASS_EN defined:
  - Applies when the queue is empty, the cycle is advancing (no flush, ramSlot or loadSlot) and fetch_valid=1.
  - instruction_in and pc_in load directly into the output register at the same edge, with valid_out←1.
  - The queue is not written and count stays 0. Latency is 0 cycles beyond the register.
- IFQ_BYPASS_EN undefined:
  - The instruction is always pushed first.
  - Decode sees it one edge later.
  - In the intervening advance cycle, instruction_out=NOP and valid_out=0.

## Test plan
- Reset:
  - Stimulus: drive RSTboot low mid-cycle with count=3.
  - Required response: immediately instruction_out=16'h0800, pc_out=0, valid_out=0, count=0, fetch_ready=1.
- Stream:
  - Stimulus: push 16'h1111@pc 0, 16'h2222@1, 16'h3333@2 on consecutive cycles with no stalls.
  - Required response: outputs appear in order, one per cycle, with valid_out=1. First arrival is at edge+1, or at the same edge with IFQ_BYPASS_EN.
- Fill under stall:
  - Stimulus: hold loadSlot=1 while pushing DEPTH+1 instructions.
  - Required response: fetch_ready=0 after DEPTH pushes and count=DEPTH. After loadSlot drops, all DEPTH instructions plus the held one emerge in order.
- Bubble:
  - Stimulus: assert ramSlot for 1 cycle with 2 entries queued.
  - Required response: NOP with valid_out=0 and pc_out unchanged for that cycle. Next cycle pops the first queued entry.
- Flush:
  - Stimulus: with 3 entries queued and fetch_valid=1, assert flush.
  - Required response: count=0 and instruction_out=NOP. The concurrent instruction is dropped. The next pushed PC 16'h0040 is the next valid output.
- Wrap:
  - Stimulus: push/pop 3×DEPTH instructions with random loadSlot.
  - Required response: no loss or reordering across pointer wrap. count stays ≤DEPTH throughout.

Source files
------------

// File: rtl/if_id_queue.sv
`default_nettype none
// ============================================================================
// Module   : if_id_queue
// Purpose  : IF/ID boundary FIFO with hold/bubble/flush output register.
//            Optional same-edge empty-queue bypass: `define IFQ_BYPASS_EN
// Revision : 1.0 - initial release
// ============================================================================
module if_id_queue #(
    parameter int            IW       = 16,
    parameter int            AW       = 16,
    parameter int            DEPTH    = 4,
    parameter logic [IW-1:0] NOP      = 16'h0800,
    parameter logic [AW-1:0] PC_START = 16'h0000
) (
    input  logic                       CLK,
    input  logic                       RSTboot,
    input  logic                       fetch_valid,
    output logic                       fetch_ready,
    input  logic [IW-1:0]              instruction_in,
    input  logic [AW-1:0]              pc_in,
    input  logic                       flush,
    input  logic                       ramSlot,
    input  logic                       loadSlot,
    output logic [IW-1:0]              instruction_out,
    output logic [AW-1:0]              pc_out,
    output logic                       valid_out,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int EW = IW + AW;
    localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

    logic [EW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [IW-1:0] instr_q, instr_d;
    logic [AW-1:0] pc_q, pc_d;
    logic          valid_q, valid_d;

    logic          empty;
    logic          advance;
    logic          bypass;
    logic          push;
    logic          pop;
    logic [EW-1:0] head;

    assign empty       = (count_q == '0);
    assign fetch_ready = (count_q != C_FULL);
    assign advance     = !flush && !ramSlot && !loadSlot;
    assign head        = mem_q[rd_ptr_q];

`ifdef IFQ_BYPASS_EN
    assign bypass = advance && empty && fetch_valid;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed instruction goes straight to the output and never occupies a slot.
    assign push = fetch_valid && fetch_ready && !flush && !bypass;
    assign pop  = advance && !empty;

    always_comb begin
        instr_d  = instr_q;
        pc_d     = pc_q;
        valid_d  = valid_q;
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (flush) begin
            instr_d  = NOP;
            valid_d  = 1'b0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else if (ramSlot) begin
            instr_d = NOP;
            valid_d = 1'b0;
        end else if (loadSlot) begin
            valid_d = valid_q;
        end else if (!empty) begin
            instr_d = head[EW-1:AW];
            pc_d    = head[AW-1:0];
            valid_d = 1'b1;
        end else if (bypass) begin
            instr_d = instruction_in;
            pc_d    = pc_in;
            valid_d = 1'b1;
        end else begin
            instr_d = NOP;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {instruction_in, pc_in};
        end
    end

    always_ff @(posedge CLK or negedge RSTboot) begin
        if (!RSTboot) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            instr_q  <= NOP;
            pc_q     <= PC_START;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            instr_q  <= instr_d;
            pc_q     <= pc_d;
            valid_q  <= valid_d;
        end
    end

    assign instruction_out = instr_q;
    assign pc_out          = pc_q;
    assign valid_out       = valid_q;
    assign count           = count_q;

endmodule
`default_nettype wire

// File: tb/tb_if_id_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_id_queue
// Purpose  : Directed + randomized bench for if_id_queue against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_id_queue;

    localparam int          DEPTH    = 4;
    localparam logic [15:0] NOP      = 16'h0800;
    localparam logic [15:0] PC_START = 16'h0000;

    logic        CLK = 1'b0;
    logic        RSTboot = 1'b0;
    logic        fetch_valid = 1'b0;
    logic        fetch_ready;
    logic [15:0] instruction_in = '0;
    logic [15:0] pc_in = '0;
    logic        flush = 1'b0;
    logic        ramSlot = 1'b0;
    logic        loadSlot = 1'b0;
    logic [15:0] instruction_out;
    logic [15:0] pc_out;
    logic        valid_out;
    logic [2:0]  count;

    if_id_queue #(
        .IW(16), .AW(16), .DEPTH(DEPTH), .NOP(NOP), .PC_START(PC_START)
    ) dut (
        .CLK(CLK), .RSTboot(RSTboot),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
        .instruction_in(instruction_in), .pc_in(pc_in),
        .flush(flush), .ramSlot(ramSlot), .loadSlot(loadSlot),
        .instruction_out(instruction_out), .pc_out(pc_out),
        .valid_out(valid_out), .count(count)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Reference: a queue of {instr, pc} plus the decode-side register.
    logic [31:0] mq[$];
    logic [15:0] m_instr;
    logic [15:0] m_pc;
    logic        m_valid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_instr = NOP;
        m_pc    = PC_START;
        m_valid = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ":instr"}, 32'(instruction_out), 32'(m_instr));
        chk({tag, ":pc"},    32'(pc_out),          32'(m_pc));
        chk({tag, ":valid"}, 32'(valid_out),       32'(m_valid));
        chk({tag, ":count"}, 32'(count),           32'(mq.size()));
        chk({tag, ":ready"}, 32'(fetch_ready),     32'(mq.size() != DEPTH));
    endtask

    task automatic step(input string tag, input logic fv, input logic [15:0] ins,
                        input logic [15:0] pc, input logic fl, input logic rs,
                        input logic ls, output logic acc);
        logic        ready;
        logic        adv;
        logic        byp;
        logic [31:0] e;
        fetch_valid    = fv;
        instruction_in = ins;
        pc_in          = pc;
        flush          = fl;
        ramSlot        = rs;
        loadSlot       = ls;
        ready = (mq.size() != DEPTH);
        acc   = 1'b0;
        if (fl) begin
            mq.delete();
            m_instr = NOP;
            m_valid = 1'b0;
        end else begin
            adv = !rs && !ls;
            byp = 1'b0;
`ifdef IFQ_BYPASS_EN
            byp = adv && (mq.size() == 0) && fv;
`endif
            if (rs) begin
                m_instr = NOP;
                m_valid = 1'b0;
            end else if (ls) begin
                m_valid = m_valid;
            end else if (mq.size() > 0) begin
                e       = mq.pop_front();
                m_instr = e[31:16];
                m_pc    = e[15:0];
                m_valid = 1'b1;
            end else if (byp) begin
                m_instr = ins;
                m_pc    = pc;
                m_valid = 1'b1;
                acc     = 1'b1;
            end else begin
                m_instr = NOP;
                m_valid = 1'b0;
            end
            if (fv && ready && !byp) begin
                mq.push_back({ins, pc});
                acc = 1'b1;
            end
        end
        @(posedge CLK);
        #1;
        check_all(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic acc;
    int   sent;

    initial begin
        // Power-on reset
        model_reset();
        #12;
        check_all("reset");
        RSTboot = 1'b1;

        // Stream of three back-to-back instructions
        step("stream0", 1, 16'h1111, 16'h0000, 0, 0, 0, acc);
        step("stream1", 1, 16'h2222, 16'h0001, 0, 0, 0, acc);
        step("stream2", 1, 16'h3333, 16'h0002, 0, 0, 0, acc);
        for (int i = 0; i < 3; i++) step("stream_drain", 0, 16'h0, 16'h0, 0, 0, 0, acc);

        // Fill under load stall, the extra instruction is held by fetch
        sent = 0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            step("fill", 1, 16'hA000 + 16'(sent), 16'h0100 + 16'(sent), 0, 0, 1, acc);
            if (acc) sent++;
        end
        chk("fill:count_full", 32'(count), DEPTH);
        chk("fill:ready_low", 32'(fetch_ready), 0);
        for (int i = 0; i < DEPTH + 4; i++) begin
            step("fill_drain", sent < DEPTH + 1, 16'hA000 + 16'(sent), 16'h0100 + 16'(sent),
                 0, 0, 0, acc);
            if (acc) sent++;
        end

        // Bubble with two entries queued
        step("bub_q0", 1, 16'hB001, 16'h0301, 0, 0, 1, acc);
        step("bub_q1", 1, 16'hB002, 16'h0302, 0, 0, 1, acc);
        step("bubble", 0, 16'h0, 16'h0, 0, 1, 0, acc);
        chk("bubble:nop", 32'(instruction_out), 32'(NOP));
        for (int i = 0; i < 3; i++) step("bub_drain", 0, 16'h0, 16'h0, 0, 0, 0, acc);

        // Flush with three entries queued and a concurrent fetch
        for (int i = 0; i < 3; i++)
            step("fl_q", 1, 16'hC000 + 16'(i), 16'h0400 + 16'(i), 0, 0, 1, acc);
        step("flush", 1, 16'hDEAD, 16'h0099, 1, 0, 0, acc);
        chk("flush:count0", 32'(count), 0);
        chk("flush:nop", 32'(instruction_out), 32'(NOP));
        step("fl_target", 1, 16'h4444, 16'h0040, 0, 0, 0, acc);
        for (int i = 0; i < 2; i++) step("fl_drain", 0, 16'h0, 16'h0, 0, 0, 0, acc);

        // Randomized traffic across pointer wrap
        sent = 0;
        for (int i = 0; i < 300 && sent < 3 * DEPTH; i++) begin
            step("wrap", $urandom_range(0, 3) != 0, 16'h5000 + 16'(sent), 16'h0200 + 16'(sent),
                 0, 0, $urandom_range(0, 2) == 0, acc);
            chk("wrap:count_bound", 32'(count <= DEPTH), 1);
            if (acc) sent++;
        end
        chk("wrap:all_pushed", sent, 3 * DEPTH);
        for (int i = 0; i < DEPTH + 2; i++) step("wrap_drain", 0, 16'h0, 16'h0, 0, 0, 0, acc);

        // Asynchronous reset mid-cycle with three entries queued
        for (int i = 0; i < 3; i++)
            step("rst_q", 1, 16'hE000 + 16'(i), 16'h0500 + 16'(i), 0, 0, 1, acc);
        fetch_valid = 1'b0;
        loadSlot    = 1'b0;
        RSTboot     = 1'b0;
        #1;
        model_reset();
        check_all("rst_mid");
        #1;
        RSTboot = 1'b1;
        step("rst_after", 1, 16'h7777, 16'h0010, 0, 0, 0, acc);
        step("rst_after2", 0, 16'h0, 16'h0, 0, 0, 0, acc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
